config_accumulator: RTL and testbench



---
 rtl/config_accumulator.sv | 152 +++++++++++++++
 tb/tb_config_accumulator.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/config_accumulator.sv
// Runtime-configurable signed burst accumulator: 1, 2 or 4 carry-isolated lanes with guard bits.
// Define CONFIG_ACC_SAT_EN to clamp overflowing lanes; otherwise lanes wrap.
module config_accumulator #(
    parameter int P  = 16,
    parameter int G  = 2,
    parameter int CW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [CW-1:0]     len,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [P-1:0]      a,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [P+4*G-1:0]  sum,
    output logic [3:0]        overflow,
    output logic [1:0]        dbg_state_o
);
    // Handshakes: a beat transfers on a rising edge where in_valid && in_ready;
    // a result transfers where out_valid && out_ready. Neither ready depends on its valid.
    localparam int S  = P/4 + G;
    localparam int W  = P + 4*G;
    localparam int H  = 2*S;
    localparam int PH = P/2;
    localparam int PQ = P/4;

`ifdef CONFIG_ACC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, OUTPUT = 2'd2} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   sum_q, sum_d;
    logic [3:0]     ovf_q, ovf_d;
    logic [1:0]     mode_q, mode_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [W-1:0]   add_res;
    logic [3:0]     add_ovf;
    logic [W-1:0]   f_op, f_res;
    logic [H-1:0]   h_cur, h_op, h_res;
    logic [S-1:0]   q_cur, q_op, q_res;
    logic           f_ovf, h_ovf, q_ovf;

    // Lane adders: each lane sign-extends its slice of a and never sees a neighbour's carry.
    always_comb begin
        add_res = sum_q;
        add_ovf = '0;
        f_op = '0; f_res = '0; f_ovf = 1'b0;
        h_cur = '0; h_op = '0; h_res = '0; h_ovf = 1'b0;
        q_cur = '0; q_op = '0; q_res = '0; q_ovf = 1'b0;
        case (mode_q)
            2'b01: begin
                for (int k = 0; k < 2; k++) begin
                    h_cur = sum_q[k*H +: H];
                    h_op  = {{(H-PH){a[k*PH+PH-1]}}, a[k*PH +: PH]};
                    h_res = h_cur + h_op;
                    h_ovf = (h_cur[H-1] == h_op[H-1]) && (h_res[H-1] != h_cur[H-1]);
                    if (SAT_EN && h_ovf)
                        h_res = h_cur[H-1] ? {1'b1, {(H-1){1'b0}}} : {1'b0, {(H-1){1'b1}}};
                    add_res[k*H +: H] = h_res;
                    add_ovf[k] = h_ovf;
                end
            end
            2'b10: begin
                for (int k = 0; k < 4; k++) begin
                    q_cur = sum_q[k*S +: S];
                    q_op  = {{(S-PQ){a[k*PQ+PQ-1]}}, a[k*PQ +: PQ]};
                    q_res = q_cur + q_op;
                    q_ovf = (q_cur[S-1] == q_op[S-1]) && (q_res[S-1] != q_cur[S-1]);
                    if (SAT_EN && q_ovf)
                        q_res = q_cur[S-1] ? {1'b1, {(S-1){1'b0}}} : {1'b0, {(S-1){1'b1}}};
                    add_res[k*S +: S] = q_res;
                    add_ovf[k] = q_ovf;
                end
            end
            default: begin
                f_op  = {{(W-P){a[P-1]}}, a};
                f_res = sum_q + f_op;
                f_ovf = (sum_q[W-1] == f_op[W-1]) && (f_res[W-1] != sum_q[W-1]);
                if (SAT_EN && f_ovf)
                    f_res = sum_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
                add_res = f_res;
                add_ovf[0] = f_ovf;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sum_d   = '0;
                    ovf_d   = '0;
                    mode_d  = (mode == 2'b11) ? 2'b00 : mode;
                    cnt_d   = len;
                    state_d = (len == '0) ? OUTPUT : ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    sum_d = add_res;
                    ovf_d = ovf_q | add_ovf;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1))
                        state_d = OUTPUT;
                end
            end
            OUTPUT: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sum_q   <= '0;
            ovf_q   <= '0;
            mode_q  <= 2'b00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign in_ready    = (state_q == ACCUM);
    assign out_valid   = (state_q == OUTPUT);
    assign sum         = sum_q;
    assign overflow    = ovf_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_config_accumulator.sv
// Bench for config_accumulator: stimulus table, hand-written corner sequences and randomized
// bursts checked against an integer lane model (P=16, G=2: lanes of 24, 12 or 6 bits).
module tb_config_accumulator;
    localparam int P  = 16;
    localparam int G  = 2;
    localparam int CW = 8;
    localparam int W  = P + 4*G;

`ifdef CONFIG_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    mode;
    logic [CW-1:0] len;
    logic          busy;
    logic          in_valid;
    logic          in_ready;
    logic [P-1:0]  a;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic [3:0]    overflow;
    logic [1:0]    dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [P-1:0] beats[$];

    config_accumulator #(.P(P), .G(G), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .len(len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .overflow(overflow), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Each lane is an integer bounded to its signed range; leaving the range flags the lane
    // and either wraps by 2^width or clamps to the bound.
    function automatic void model(input logic [1:0] m, input int n,
                                  output logic [W-1:0] s, output logic [3:0] o);
        int nl, lw, fw;
        longint acc, fld, lmax, lmin;
        nl = (m == 2'b01) ? 2 : (m == 2'b10) ? 4 : 1;
        lw = W / nl;
        fw = P / nl;
        s = '0;
        o = '0;
        for (int k = 0; k < nl; k++) begin
            acc  = 0;
            lmax = (longint'(1) << (lw-1)) - 1;
            lmin = -(longint'(1) << (lw-1));
            for (int i = 0; i < n; i++) begin
                fld = longint'(beats[i] >> (k*fw)) & ((longint'(1) << fw) - 1);
                if (fld > ((longint'(1) << (fw-1)) - 1))
                    fld = fld - (longint'(1) << fw);
                acc = acc + fld;
                if (acc > lmax) begin
                    o[k] = 1'b1;
                    acc = SAT ? lmax : acc - (longint'(1) << lw);
                end else if (acc < lmin) begin
                    o[k] = 1'b1;
                    acc = SAT ? lmin : acc + (longint'(1) << lw);
                end
            end
            s = s | (W'(acc & ((longint'(1) << lw) - 1)) << (k*lw));
        end
    endfunction

    task automatic run_burst(input logic [1:0] m, input int l, input int stall_pct,
                             input int stall_at, input logic [W-1:0] exp_s, input logic [3:0] exp_o);
        int idx;
        int guard;
        int hold;
        int st_at;
        logic acc;
        st_at = stall_at;
        start = 1'b1; mode = m; len = CW'(l);
        in_valid = 1'b1; a = 16'($urandom);
        tick();
        start = 1'b0; mode = 2'($urandom); len = CW'($urandom);
        check("busy_after_start", busy, 1);
        idx = 0;
        guard = 0;
        while (idx < l && guard < 500) begin
            if (idx == st_at) begin
                repeat (4) begin
                    in_valid = 1'b0; a = 16'($urandom);
                    tick();
                    check("stall_in_ready", in_ready, 1);
                end
                st_at = -1;
            end
            in_valid = ($urandom_range(99, 0) >= 32'(stall_pct));
            a = in_valid ? beats[idx] : 16'($urandom);
            check("no_early_out_valid", out_valid, 0);
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
            guard++;
        end
        in_valid = 1'b0;
        if (idx < l) check("burst_timeout", idx, l);
        check("out_valid_latency", out_valid, 1);
        check("in_ready_in_output", in_ready, 0);
        check("sum", sum, exp_s);
        check("overflow", overflow, exp_o);
        hold = $urandom_range(3, 1);
        repeat (hold) begin
            out_ready = 1'b0; start = 1'b1; in_valid = 1'($urandom); a = 16'($urandom);
            tick();
            check("hold_sum", sum, exp_s);
            check("hold_overflow", overflow, exp_o);
            check("hold_out_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        start = 1'($urandom);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0; start = 1'b0;
        check("release_out_valid", out_valid, 0);
        check("release_idle", busy, 0);
    endtask

    typedef struct {
        logic [1:0]    m;
        int            l;
        logic [P-1:0]  a;
        logic [W-1:0]  s;
        logic [3:0]    o;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [W-1:0] es;
        logic [3:0]   eo;
        logic [1:0]   rm;
        int           rl;

        vecs[0] = '{2'b00, 3, 16'h7FFF, 24'h017FFD, 4'b0000};
        vecs[1] = '{2'b10, 2, 16'h7F81, 24'h3BEC02, 4'b0000};
        vecs[2] = '{2'b10, 5, 16'h0007, SAT ? 24'h00001F : 24'h000023, 4'b0001};
        vecs[3] = '{2'b00, 0, 16'h1234, 24'h000000, 4'b0000};
        vecs[4] = '{2'b01, 2, 16'h8080, 24'hF00F00, 4'b0000};
        vecs[5] = '{2'b11, 1, 16'h8000, 24'hFF8000, 4'b0000};
        vecs[6] = '{2'b01, 17, 16'h007F, SAT ? 24'h0007FF : 24'h00086F, 4'b0001};
        vecs[7] = '{2'b10, 5, 16'h8000, SAT ? 24'h800000 : 24'h600000, 4'b1000};

        rst = 1'b1; start = 1'b0; mode = 2'b00; len = '0;
        in_valid = 1'b0; a = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_sum", sum, 0);
        check("reset_overflow", overflow, 0);
        check("reset_state", dbg_state, 0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 8; v++) begin
            beats.delete();
            for (int j = 0; j < vecs[v].l; j++) beats.push_back(vecs[v].a);
            run_burst(vecs[v].m, vecs[v].l, 0, -1, vecs[v].s, vecs[v].o);
        end

        // Same beats with and without a 4-cycle mid-burst stall must give the same result.
        beats.delete();
        for (int j = 0; j < 4; j++) beats.push_back(16'($urandom));
        model(2'b10, 4, es, eo);
        run_burst(2'b10, 4, 0, 2, es, eo);
        run_burst(2'b10, 4, 0, -1, es, eo);

        // Asynchronous reset after the first of three beats.
        beats.delete();
        for (int j = 0; j < 3; j++) beats.push_back(16'($urandom));
        start = 1'b1; mode = 2'b00; len = CW'(3);
        tick();
        start = 1'b0; in_valid = 1'b1; a = beats[0];
        tick();
        a = beats[1];
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sum", sum, 0);
        check("midrst_overflow", overflow, 0);
        tick();
        rst = 1'b0; in_valid = 1'b0;
        tick();
        check("post_rst_idle", busy, 0);
        model(2'b00, 3, es, eo);
        run_burst(2'b00, 3, 0, -1, es, eo);

        for (int r = 0; r < 25; r++) begin
            rm = 2'($urandom_range(3, 0));
            rl = $urandom_range(12, 0);
            beats.delete();
            for (int j = 0; j < rl; j++) beats.push_back(16'($urandom));
            model(rm, rl, es, eo);
            run_burst(rm, rl, 30, -1, es, eo);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
